// File: rtl/div_n_prog_if.sv
// Bus between a requester and the programmable clock divider.
//   en        : requester -> divider, 1 = divide, 0 = hold idle
//   div_ratio : requester -> divider, requested ratio N (0/1 treated as 2)
//   fout      : divider -> requester, divided clock (registered)
//   tc        : divider -> requester, pulse on the last cycle of each fout period
//   ratio_cur : divider -> requester, clamped ratio in use for the current period
interface div_n_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_ratio;
    logic             fout;
    logic             tc;
    logic [WIDTH-1:0] ratio_cur;

    modport master (output en, output div_ratio, input fout, input tc, input ratio_cur);
    modport slave  (input en, input div_ratio, output fout, output tc, output ratio_cur);
endinterface

// File: rtl/div_n_prog.sv
// Programmable integer clock divider.
// Divides clk by a runtime ratio N (2..2^WIDTH-1) with near-50% duty
// (high ceil(N/2), low floor(N/2)) and a one-cycle terminal-count pulse.
// A new ratio is only taken at a period boundary, so the output never
// shows truncated or stretched pulses.
// Ports:
//   clk   : input clock, all logic on rising edge
//   rst_n : synchronous active-low reset
//   bus   : div_n_prog_if.slave (en, div_ratio in; fout, tc, ratio_cur out)
module div_n_prog #(
    parameter int WIDTH     = 8,
    parameter int RST_RATIO = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    div_n_prog_if.slave         bus
);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_R = WIDTH'(RST_RATIO);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             fout_q, fout_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] nc;
    logic [WIDTH-1:0] high_len;
    logic             last;

    always_comb begin
        // Ratios below 2 cannot form a high and a low phase; force 2.
        nc       = (bus.div_ratio < TWO) ? TWO : bus.div_ratio;
        // ceil(N/2); fits in WIDTH bits even for N = 2^WIDTH-1.
        high_len = (ratio_q >> 1) + {{(WIDTH-1){1'b0}}, ratio_q[0]};
        last     = (cnt_q == ratio_q - ONE);

        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        fout_d  = fout_q;
        tc_d    = tc_q;

        if (!bus.en) begin
            // Idle: keep tracking the request so the first enabled
            // period already uses it.
            cnt_d   = ZERO;
            fout_d  = 1'b0;
            tc_d    = 1'b0;
            ratio_d = nc;
        end else begin
            cnt_d  = last ? ZERO : cnt_q + ONE;
            fout_d = (cnt_q < high_len);
            tc_d   = last;
            if (last) begin
                ratio_d = nc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= ZERO;
            ratio_q <= RST_R;
            fout_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            fout_q  <= fout_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.fout      = fout_q;
    assign bus.tc        = tc_q;
    assign bus.ratio_cur = ratio_q;

endmodule
